// File: rtl/simple_fixed_pipe.sv
// simple_fixed_pipe: pipelined SIMD byte/halfword/word add/subtract with carry/borrow generation, stall and flush.
module simple_fixed_pipe #(
    parameter int VEC_W = 128,
    parameter int STAGES = 3,
    parameter logic [2:0] UNIT_ID = 3'd1,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [1:0]        esize,
    input  logic              use_imm,
    input  logic [9:0]        imm10,
    input  logic [VEC_W-1:0]  ra,
    input  logic [VEC_W-1:0]  rb,
    input  logic [VEC_W-1:0]  rc,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [VEC_W-1:0]  out_value,
    output logic [ADDR_W-1:0] out_rt_addr,
    output logic [2:0]        out_unit_id,
    output logic              out_err
);
    logic sub, xop, err;
    logic [VEC_W-1:0] s8, s16, s32, res;
    logic [32:0] w;
    logic              v_q [STAGES];
    logic [VEC_W-1:0]  d_q [STAGES];
    logic [ADDR_W-1:0] a_q [STAGES];
    logic              e_q [STAGES];
    assign sub = op_sel[0];
    assign xop = op_sel == 3'd2 || op_sel == 3'd3;
    assign err = op_sel > 3'd5 || esize == 2'd3 || (op_sel > 3'd1 && esize != 2'd2);
    // Every op is b + (a or ~a) + cin; CG/BG keep only the carry-out of that sum.
    always_comb begin
        s8 = '0;
        s16 = '0;
        s32 = '0;
        w = '0;
        for (int i = 0; i < VEC_W/8; i++)
            s8[i*8 +: 8] = (use_imm ? imm10[7:0] : rb[i*8 +: 8]) + (sub ? ~ra[i*8 +: 8] : ra[i*8 +: 8]) + {7'b0, sub};
        for (int i = 0; i < VEC_W/16; i++)
            s16[i*16 +: 16] = (use_imm ? {{6{imm10[9]}}, imm10} : rb[i*16 +: 16]) + (sub ? ~ra[i*16 +: 16] : ra[i*16 +: 16]) + {15'b0, sub};
        for (int i = 0; i < VEC_W/32; i++) begin
            w = {1'b0, use_imm ? {{22{imm10[9]}}, imm10} : rb[i*32 +: 32]} + {1'b0, sub ? ~ra[i*32 +: 32] : ra[i*32 +: 32]} + {32'b0, xop ? rc[i*32] : sub};
            s32[i*32 +: 32] = op_sel[2] ? {31'b0, w[32]} : w[31:0];
        end
        res = err ? '0 : esize == 2'd0 ? s8 : esize == 2'd1 ? s16 : s32;
    end
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                d_q[s] <= '0;
                a_q[s] <= '0;
                e_q[s] <= 1'b0;
            end
        end else if (!stall) begin
            v_q[0] <= in_valid;
            d_q[0] <= in_valid ? res : '0;
            a_q[0] <= in_valid ? rt_addr : '0;
            e_q[0] <= in_valid && err;
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
                d_q[s] <= d_q[s-1];
                a_q[s] <= a_q[s-1];
                e_q[s] <= e_q[s-1];
            end
        end
    end
    assign in_ready    = !stall;
    assign out_valid   = v_q[STAGES-1];
    assign out_value   = d_q[STAGES-1];
    assign out_rt_addr = a_q[STAGES-1];
    assign out_err     = e_q[STAGES-1];
    assign out_unit_id = out_valid ? UNIT_ID : 3'd0;
endmodule

// File: tb/tb_simple_fixed_pipe.sv
// tb_simple_fixed_pipe: directed and randomized checks of simple_fixed_pipe against an element-wise arithmetic model.
module tb_simple_fixed_pipe;
    localparam int VEC_W = 128;
    localparam int STAGES = 3;
    localparam int ADDR_W = 7;
    typedef struct packed {
        logic [VEC_W-1:0]  v;
        logic [ADDR_W-1:0] a;
        logic              e;
    } res_t;
    logic clock = 0;
    logic reset, in_valid, in_ready, use_imm, stall, flush, out_valid, out_err;
    logic [2:0] op_sel, out_unit_id;
    logic [1:0] esize;
    logic [9:0] imm10;
    logic [VEC_W-1:0] ra, rb, rc, out_value;
    logic [ADDR_W-1:0] rt_addr, out_rt_addr;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clock = ~clock;
    simple_fixed_pipe #(.VEC_W(VEC_W), .STAGES(STAGES), .UNIT_ID(3'd1), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
        .esize(esize), .use_imm(use_imm), .imm10(imm10), .ra(ra), .rb(rb), .rc(rc), .rt_addr(rt_addr),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_value(out_value),
        .out_rt_addr(out_rt_addr), .out_unit_id(out_unit_id), .out_err(out_err)
    );
    // Reference: element k counted from the MSB end, plain integer arithmetic per element.
    function automatic logic [VEC_W-1:0] model(input logic [2:0] op, input logic [1:0] es, input logic ui,
                                                input logic [9:0] imm, input logic [VEC_W-1:0] av, bv, cv,
                                                output logic er);
        logic [VEC_W-1:0] r_v, t;
        longint unsigned a, b, c, m, r;
        longint si;
        int e, lo;
        er = op > 3'd5 || es == 2'd3 || (op > 3'd1 && es != 2'd2);
        r_v = '0;
        if (!er) begin
            e = 8 << es;
            m = (64'd1 << e) - 64'd1;
            si = longint'($signed(imm));
            for (int k = 0; k < VEC_W / e; k++) begin
                lo = VEC_W - (k + 1) * e;
                t = av >> lo;
                a = t[63:0] & m;
                t = bv >> lo;
                b = ui ? ($unsigned(si) & m) : (t[63:0] & m);
                t = cv >> lo;
                c = t[63:0] & 64'd1;
                case (op)
                    3'd0: r = a + b;
                    3'd1: r = b - a;
                    3'd2: r = a + b + c;
                    3'd3: r = b - a - 64'd1 + c;
                    3'd4: r = (a + b) >> 32;
                    default: r = (b >= a) ? 64'd1 : 64'd0;
                endcase
                t = VEC_W'(r & m);
                r_v = r_v | (t << lo);
            end
        end
        return r_v;
    endfunction
    function automatic logic [VEC_W-1:0] rvec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic idle();
        in_valid = 0; op_sel = 0; esize = 0; use_imm = 0; imm10 = 0;
        ra = '0; rb = '0; rc = '0; rt_addr = '0;
    endtask
    task automatic present(input logic [2:0] op, input logic [1:0] es, input logic ui, input logic [9:0] imm,
                           input logic [VEC_W-1:0] a, b, c, input logic [ADDR_W-1:0] ad);
        in_valid = 1; op_sel = op; esize = es; use_imm = ui; imm10 = imm;
        ra = a; rb = b; rc = c; rt_addr = ad;
    endtask
    task automatic run_single(input logic [2:0] op, input logic [1:0] es, input logic ui, input logic [9:0] imm,
                              input logic [VEC_W-1:0] a, b, c, input logic [ADDR_W-1:0] ad,
                              output logic early, output logic ov, output logic [VEC_W-1:0] val,
                              output logic [2:0] uid, output logic [ADDR_W-1:0] rta, output logic er);
        present(op, es, ui, imm, a, b, c, ad);
        tick();
        idle();
        repeat (STAGES - 2) tick();
        early = out_valid;
        tick();
        ov = out_valid; val = out_value; uid = out_unit_id; rta = out_rt_addr; er = out_err;
    endtask
    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        idle();
        tick();
        tick();
        reset = 0;
        n_cmp++;
        if ({out_valid, out_value, out_rt_addr, out_unit_id, out_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b val=%h addr=%h uid=%0d err=%b, need all zero",
                     out_valid, out_value, out_rt_addr, out_unit_id, out_err);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b need 1", in_ready); end
    endtask
    task automatic test_word_add();
        logic early, ov, er;
        logic [VEC_W-1:0] val;
        logic [2:0] uid;
        logic [ADDR_W-1:0] rta;
        run_single(3'd0, 2'd2, 1'b0, 10'd0, {(VEC_W/32){32'hFFFF_FFFF}}, {(VEC_W/32){32'h1}}, '0, 7'h2A,
                   early, ov, val, uid, rta, er);
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL wadd_early: valid %b one cycle early, need 0", early); end
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL wadd_valid: got %b need 1", ov); end
        n_cmp++; if (val !== '0) begin n_bad++; $display("FAIL wadd_value: got %h need 0", val); end
        n_cmp++; if (uid !== 3'd1) begin n_bad++; $display("FAIL wadd_unit: got %0d need 1", uid); end
        n_cmp++; if (rta !== 7'h2A) begin n_bad++; $display("FAIL wadd_addr: got %h need 2a", rta); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wadd_err: got %b need 0", er); end
    endtask
    task automatic test_hw_subf_imm();
        logic early, ov, er;
        logic [VEC_W-1:0] val;
        logic [2:0] uid;
        logic [ADDR_W-1:0] rta;
        run_single(3'd1, 2'd1, 1'b1, 10'h3FF, {(VEC_W/16){16'h0005}}, rvec(), '0, 7'h03,
                   early, ov, val, uid, rta, er);
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL hsubf_valid: got %b need 1", ov); end
        n_cmp++;
        if (val !== {(VEC_W/16){16'hFFFA}}) begin
            n_bad++; $display("FAIL hsubf_value: got %h need %h", val, {(VEC_W/16){16'hFFFA}});
        end
    endtask
    task automatic test_byte();
        logic early, ov, er;
        logic [VEC_W-1:0] val;
        logic [2:0] uid;
        logic [ADDR_W-1:0] rta;
        run_single(3'd0, 2'd0, 1'b0, 10'd0, {(VEC_W/8){8'h7F}}, {(VEC_W/8){8'h01}}, '0, 7'h11,
                   early, ov, val, uid, rta, er);
        n_cmp++;
        if (val !== {(VEC_W/8){8'h80}}) begin n_bad++; $display("FAIL badd_value: got %h need %h", val, {(VEC_W/8){8'h80}}); end
        run_single(3'd2, 2'd0, 1'b0, 10'd0, {(VEC_W/8){8'h7F}}, {(VEC_W/8){8'h01}}, '1, 7'h12,
                   early, ov, val, uid, rta, er);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL baddx_err: got %b need 1", er); end
        n_cmp++; if (val !== '0) begin n_bad++; $display("FAIL baddx_value: got %h need 0", val); end
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL baddx_valid: got %b need 1", ov); end
    endtask
    task automatic test_cg_addx();
        logic early, ov, er;
        logic [VEC_W-1:0] val, a, need;
        logic [2:0] uid;
        logic [ADDR_W-1:0] rta;
        a = {32'h8000_0000, {(VEC_W-32){1'b0}}};
        need = {32'd1, {(VEC_W-32){1'b0}}};
        run_single(3'd4, 2'd2, 1'b0, 10'd0, a, a, '0, 7'h21, early, ov, val, uid, rta, er);
        n_cmp++; if (val !== need) begin n_bad++; $display("FAIL cg_value: got %h need %h", val, need); end
        run_single(3'd2, 2'd2, 1'b0, 10'd0, a, a, need, 7'h22, early, ov, val, uid, rta, er);
        n_cmp++; if (val !== need) begin n_bad++; $display("FAIL addx_value: got %h need %h", val, need); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL addx_err: got %b need 0", er); end
    endtask
    // Scoreboard stream: rnd=0 issues 4 with a 2-cycle stall mid-stream, rnd=1 randomizes issue and stall.
    task automatic test_stream(input int n, input bit rnd);
        res_t q[$];
        res_t e, snap;
        logic [2:0] op;
        logic [1:0] es;
        logic ui, st, er, pv;
        logic [9:0] imm;
        logic [VEC_W-1:0] a, b, c, v;
        int issued = 0, cyc = 0;
        while ((issued < n || q.size() > 0) && cyc < 400) begin
            st = rnd ? ($urandom_range(0, 3) == 0) : (cyc == 3 || cyc == 4);
            stall = st;
            if (issued < n && (!rnd || $urandom_range(0, 4) != 0)) begin
                op = 3'($urandom_range(0, 7));
                es = (op inside {[3'd2:3'd5]} && $urandom_range(0, 3) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
                ui = 1'($urandom_range(0, 1));
                imm = 10'($urandom);
                a = rvec(); b = rvec(); c = rvec();
                present(op, es, ui, imm, a, b, c, ADDR_W'(issued));
                if (!st) begin
                    v = model(op, es, ui, imm, a, b, c, er);
                    q.push_back('{v: v, a: ADDR_W'(issued), e: er});
                    issued++;
                end
            end else idle();
            #1;
            n_cmp++;
            if (in_ready !== !st) begin n_bad++; $display("FAIL stream_ready: got %b need %b", in_ready, !st); end
            snap = '{v: out_value, a: out_rt_addr, e: out_err};
            pv = out_valid;
            tick();
            cyc++;
            if (st) begin
                n_cmp++;
                if ({out_valid, out_value, out_rt_addr, out_err} !== {pv, snap}) begin
                    n_bad++;
                    $display("FAIL stream_hold: got v=%b addr=%h val=%h need v=%b addr=%h val=%h",
                             out_valid, out_rt_addr, out_value, pv, snap.a, snap.v);
                end
            end else if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL stream_spurious: result addr=%h with nothing outstanding", out_rt_addr);
                end else begin
                    e = q.pop_front();
                    if ({out_value, out_rt_addr, out_err} !== e) begin
                        n_bad++;
                        $display("FAIL stream_result: got addr=%h err=%b val=%h need addr=%h err=%b val=%h",
                                 out_rt_addr, out_err, out_value, e.a, e.e, e.v);
                    end
                end
            end
        end
        stall = 0;
        idle();
        n_cmp++;
        if (q.size() != 0 || issued != n) begin
            n_bad++; $display("FAIL stream_drain: %0d outstanding, %0d of %0d issued", q.size(), issued, n);
        end
    endtask
    task automatic test_flush();
        present(3'd0, 2'd2, 1'b0, 10'd0, rvec(), rvec(), '0, 7'h31);
        tick();
        present(3'd0, 2'd2, 1'b0, 10'd0, rvec(), rvec(), '0, 7'h32);
        tick();
        present(3'd0, 2'd2, 1'b0, 10'd0, rvec(), rvec(), '0, 7'h33);
        flush = 1;
        stall = 1;
        tick();
        flush = 0;
        stall = 0;
        idle();
        for (int i = 0; i < STAGES + 2; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_kill: cycle %0d valid=%b addr=%h need valid 0", i, out_valid, out_rt_addr); end
            tick();
        end
    endtask
    task automatic test_reset_mid();
        logic early, ov, er;
        logic [VEC_W-1:0] val, a, b, need;
        logic [2:0] uid;
        logic [ADDR_W-1:0] rta;
        present(3'd0, 2'd2, 1'b0, 10'd0, rvec(), rvec(), '0, 7'h41);
        tick();
        present(3'd1, 2'd1, 1'b0, 10'd0, rvec(), rvec(), '0, 7'h42);
        tick();
        reset = 1; stall = 1; flush = 1;
        tick();
        reset = 0; stall = 0; flush = 0;
        idle();
        n_cmp++;
        if ({out_valid, out_value, out_rt_addr, out_unit_id, out_err} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got v=%b val=%h addr=%h uid=%0d err=%b, need all zero",
                     out_valid, out_value, out_rt_addr, out_unit_id, out_err);
        end
        a = rvec(); b = rvec();
        need = model(3'd0, 2'd2, 1'b0, 10'd0, a, b, '0, er);
        run_single(3'd0, 2'd2, 1'b0, 10'd0, a, b, '0, 7'h43, early, ov, val, uid, rta, er);
        n_cmp++; if (early !== 1'b0 || ov !== 1'b1) begin n_bad++; $display("FAIL midreset_latency: early=%b final=%b need 0 then 1", early, ov); end
        n_cmp++; if (val !== need) begin n_bad++; $display("FAIL midreset_value: got %h need %h", val, need); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        reset = 1; stall = 0; flush = 0;
        idle();
        test_reset();
        test_word_add();
        test_hw_subf_imm();
        test_byte();
        test_cg_addx();
        test_stream(4, 1'b0);
        test_flush();
        test_stream(60, 1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
